// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the NTT address/sequence controller.
// Holds the transform constants, the FSM state and mode encodings, and the
// helper that maps (stage, butterfly index, mode) to operand addresses and
// twiddle ROM index.
package ntt_ctrl_pkg;

  localparam int unsigned N            = 32'd256;
  localparam int unsigned LOG2N        = 32'd8;
  localparam int unsigned Q            = 32'd8380417;
  localparam int unsigned BF_PER_STAGE = N / 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_FWD = 1'b0,  // Cooley-Tukey, len halves each stage
    MODE_INV = 1'b1   // Gentleman-Sande, len doubles each stage
  } mode_e;

  typedef struct packed {
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [7:0] tw_k;
  } bf_addr_t;

  // Butterfly bf of stage s pairs j with j+len, where j skips over the upper
  // half of every 2*len block; g is the block number and selects the twiddle.
  function automatic bf_addr_t bf_addr(input logic [2:0] stage,
                                       input logic [6:0] bf,
                                       input mode_e      mode);
    bf_addr_t   res;
    logic [2:0] l;
    logic [3:0] lp1;
    logic [7:0] bf8;
    logic [7:0] len;
    logic [7:0] g;
    logic [7:0] j;
    l   = (mode == MODE_INV) ? stage : (3'd7 - stage);
    lp1 = {1'b0, l} + 4'd1;
    bf8 = {1'b0, bf};
    len = 8'd1 << l;
    g   = bf8 >> l;
    j   = (g << lp1) | (bf8 & (len - 8'd1));
    res.addr_a = j;
    res.addr_b = j + len;
    if (mode == MODE_INV) begin
      // (256 >> s) - 1 written as 255 >> s to stay within 8 bits
      res.tw_k = (8'd255 >> stage) - g;
    end else begin
      res.tw_k = (8'd1 << stage) + g;
    end
    return res;
  endfunction

endpackage

// File: rtl/ntt_ctrl_if.sv
// Control/memory bus between the NTT controller and its environment
// (host handshake, coefficient memory, twiddle ROM and butterfly selects).
//   master : the controller (takes start/mode, drives everything else)
//   slave  : host + datapath side
interface ntt_ctrl_if;
  import ntt_ctrl_pkg::*;

  logic               start_i;
  logic               mode_i;
  logic               busy_o;
  logic               done_o;
  logic               rd_en_o;
  logic [LOG2N-1:0]   rd_addr_a_o;
  logic [LOG2N-1:0]   rd_addr_b_o;
  logic [LOG2N-1:0]   twiddle_idx_o;
  logic               sel_butterfly_o;
  logic               sel_red_o;
  logic               wr_en_o;
  logic [LOG2N-1:0]   wr_addr_a_o;
  logic [LOG2N-1:0]   wr_addr_b_o;
  logic [2:0]         stage_o;

  modport master (
    input  start_i, mode_i,
    output busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, twiddle_idx_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o
  );

  modport slave (
    output start_i, mode_i,
    input  busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, twiddle_idx_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o
  );

endinterface

// File: rtl/ntt_delay_line.sv
// Fixed-depth register delay line; q_o is d_i delayed by DEPTH clock edges.
// Ports: clk_i, rst_i (async, active-high, clears every tap), d_i, q_o.
module ntt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift register taps, cleared on reset so no stale strobes survive an abort
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// NTT sequence controller: walks 8 stages x 128 butterflies, issuing operand
// reads, twiddle indices and butterfly selects, and aligned write-back
// strobes/addresses delayed by 1+BF_LAT cycles.
// Ports: clk_i, rst_i (async, active-high), bus (ntt_ctrl_if.master).
// All bus outputs are registered; read-side values are computed from the
// next state so that rd_en_o rises the cycle after start acceptance.
module ntt_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int BF_LAT = 0,
  parameter int N      = ntt_ctrl_pkg::N
) (
  input  logic      clk_i,
  input  logic      rst_i,
  ntt_ctrl_if.master bus
);

  localparam logic [6:0] BF_LAST    = 7'(N / 2 - 1);
  localparam logic [2:0] STAGE_LAST = 3'(LOG2N - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(BF_LAT);

  state_e     state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [6:0] bf_q, bf_d;
  logic [7:0] drain_q, drain_d;
  mode_e      mode_q, mode_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] rd_a_q, rd_a_d;
  logic [7:0] rd_b_q, rd_b_d;
  logic [7:0] rd_k_q, rd_k_d;
  logic       rd_red_q, rd_red_d;
  logic [7:0] twiddle_q;
  logic       sel_bf_q;
  logic       sel_red_q;

  bf_addr_t   addr_s;
  logic [16:0] wr_bus_s;

  // Next-state logic: stage/butterfly sequencing and drain stall
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bf_d    = bf_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_RUN;
          stage_d = 3'd0;
          bf_d    = 7'd0;
          mode_d  = mode_e'(bus.mode_i);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bf_q == BF_LAST) begin
          state_d = ST_DRAIN;
          drain_d = 8'd0;
        end else begin
          bf_d = bf_q + 7'd1;
        end
      end
      ST_DRAIN: begin
        // Hold off the next stage until the last write of this one has issued
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + 3'd1;
            bf_d    = 7'd0;
          end
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = 3'd0;
        bf_d    = 7'd0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-side output decode from the next state (lands in registers below)
  always_comb begin
    addr_s   = bf_addr(stage_d, bf_d, mode_d);
    rd_en_d  = (state_d == ST_RUN);
    busy_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
    rd_a_d   = 8'd0;
    rd_b_d   = 8'd0;
    rd_k_d   = 8'd0;
    rd_red_d = 1'b0;
    if (rd_en_d) begin
      rd_a_d   = addr_s.addr_a;
      rd_b_d   = addr_s.addr_b;
      rd_k_d   = addr_s.tw_k;
      rd_red_d = (mode_d == MODE_INV) && (stage_d == STAGE_LAST);
    end else begin
      rd_a_d   = 8'd0;
      rd_b_d   = 8'd0;
      rd_k_d   = 8'd0;
      rd_red_d = 1'b0;
    end
  end

  // State and output registers; twiddle/selects trail the read by one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      stage_q   <= 3'd0;
      bf_q      <= 7'd0;
      drain_q   <= 8'd0;
      mode_q    <= MODE_FWD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_a_q    <= 8'd0;
      rd_b_q    <= 8'd0;
      rd_k_q    <= 8'd0;
      rd_red_q  <= 1'b0;
      twiddle_q <= 8'd0;
      sel_bf_q  <= 1'b0;
      sel_red_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      bf_q      <= bf_d;
      drain_q   <= drain_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
      rd_k_q    <= rd_k_d;
      rd_red_q  <= rd_red_d;
      twiddle_q <= rd_k_q;
      sel_bf_q  <= (mode_q == MODE_INV);
      sel_red_q <= rd_red_q;
    end
  end

  ntt_delay_line #(
    .WIDTH (17),
    .DEPTH (1 + BF_LAT)
  ) u_wr_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({rd_en_q, rd_a_q, rd_b_q}),
    .q_o   (wr_bus_s)
  );

  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.rd_en_o         = rd_en_q;
  assign bus.rd_addr_a_o     = rd_a_q;
  assign bus.rd_addr_b_o     = rd_b_q;
  assign bus.twiddle_idx_o   = twiddle_q;
  assign bus.sel_butterfly_o = sel_bf_q;
  assign bus.sel_red_o       = sel_red_q;
  assign bus.wr_en_o         = wr_bus_s[16];
  assign bus.wr_addr_a_o     = wr_bus_s[15:8];
  assign bus.wr_addr_b_o     = wr_bus_s[7:0];
  assign bus.stage_o         = stage_q;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: two instances (BF_LAT = 0 and 2) share the
// same stimulus; a textbook-loop reference model queues the expected reads,
// twiddles and writes with their cycle numbers, and one monitor checks them.
module tb_ntt_ctrl;

  typedef struct {
    int cyc;
    int a;
    int b;
    int k;
    int stage;
    bit red;
    bit mode;
  } exp_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] tw;
    logic       sb;
    logic       sr;
    logic       wr_en;
    logic [7:0] wa;
    logic [7:0] wb;
    logic [2:0] st;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic start_s;
  logic mode_s;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  obs_t obs_s [2];
  exp_t rd_q [2][$];
  exp_t tw_q [2][$];
  exp_t wr_q [2][$];
  int   m_acc [2];
  int   m_done_at [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ntt_ctrl_if bus ();
    assign bus.start_i = start_s;
    assign bus.mode_i  = mode_s;
    ntt_ctrl #(.BF_LAT(gi * 2)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
    assign obs_s[gi] = {bus.busy_o, bus.done_o, bus.rd_en_o, bus.rd_addr_a_o,
                        bus.rd_addr_b_o, bus.twiddle_idx_o, bus.sel_butterfly_o,
                        bus.sel_red_o, bus.wr_en_o, bus.wr_addr_a_o,
                        bus.wr_addr_b_o, bus.stage_o};
  end

  task automatic check(input string name, input int dut, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (lat%0d) cycle %0d: got %0d, expected %0d", name, dut * 2, cyc, act, exp);
    end
  endtask

  // Monitor + reference model: sampled on the falling edge
  initial begin
    obs_t o;
    exp_t e;
    int   per, len, idx;
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = -1;
      m_done_at[d] = -1;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int d = 0; d < 2; d++) begin
          rd_q[d].delete();
          tw_q[d].delete();
          wr_q[d].delete();
          m_acc[d] = -1;
          m_done_at[d] = -1;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          o   = obs_s[d];
          per = 129 + d * 2;
          check("busy", d, o.busy, (cyc > m_acc[d] && cyc < m_done_at[d]) ? 1 : 0);
          check("done", d, o.done, (cyc == m_done_at[d]) ? 1 : 0);
          if (cyc > m_done_at[d]) begin
            check("idle_addr", d, {o.ra, o.rb, o.tw}, 0);
          end
          // read side
          if (o.rd_en) begin
            if (rd_q[d].size() == 0) begin
              check("rd_en_spurious", d, o.rd_en, 0);
            end else begin
              e = rd_q[d].pop_front();
              check("rd_cycle", d, cyc, e.cyc);
              check("rd_addr_a", d, o.ra, e.a);
              check("rd_addr_b", d, o.rb, e.b);
              check("stage", d, o.st, e.stage);
              e.cyc = cyc + 1;
              tw_q[d].push_back(e);
              e.cyc = cyc + 1 + d * 2;
              wr_q[d].push_back(e);
            end
          end else if (rd_q[d].size() > 0 && rd_q[d][0].cyc <= cyc) begin
            check("rd_en_missing", d, o.rd_en, 1);
            void'(rd_q[d].pop_front());
          end
          // twiddle / selects, one cycle after the read
          if (tw_q[d].size() > 0 && tw_q[d][0].cyc == cyc) begin
            e = tw_q[d].pop_front();
            check("twiddle_idx", d, o.tw, e.k);
            check("sel_red", d, o.sr, e.red);
            check("sel_butterfly", d, o.sb, e.mode);
          end else if (o.sr) begin
            check("sel_red_stray", d, o.sr, 0);
          end
          // write side
          if (o.wr_en) begin
            if (wr_q[d].size() == 0) begin
              check("wr_en_spurious", d, o.wr_en, 0);
            end else begin
              e = wr_q[d].pop_front();
              check("wr_cycle", d, cyc, e.cyc);
              check("wr_addr_a", d, o.wa, e.a);
              check("wr_addr_b", d, o.wb, e.b);
            end
          end else if (wr_q[d].size() > 0 && wr_q[d][0].cyc <= cyc) begin
            check("wr_en_missing", d, o.wr_en, 1);
            void'(wr_q[d].pop_front());
          end
          // acceptance: DUT idle this cycle and start seen at the coming edge
          if (cyc > m_done_at[d] && start_s) begin
            m_acc[d]     = cyc;
            m_done_at[d] = cyc + 8 * per + 1;
            for (int s = 0; s < 8; s++) begin
              len = mode_s ? (1 << s) : (128 >> s);
              idx = 0;
              for (int base = 0; base < 256; base += 2 * len) begin
                for (int j = base; j < base + len; j++) begin
                  e.cyc   = cyc + 1 + s * per + idx;
                  e.a     = j;
                  e.b     = j + len;
                  e.stage = s;
                  e.k     = mode_s ? (256 >> s) - 1 - base / (2 * len)
                                   : (1 << s) + base / (2 * len);
                  e.red   = mode_s && (s == 7);
                  e.mode  = mode_s;
                  rd_q[d].push_back(e);
                  idx++;
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic issue(input bit m);
    @(posedge clk); #1;
    start_s = 1'b1;
    mode_s  = m;
    @(posedge clk); #1;
    start_s = 1'b0;
    mode_s  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(cyc > m_done_at[0] && cyc > m_done_at[1]) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_idle_in_budget", -1, (t < 5000) ? 1 : 0, 1);
  endtask

  task automatic check_reset_outputs();
    check("reset_outputs", 0, longint'(obs_s[0]), 0);
    check("reset_outputs", 1, longint'(obs_s[1]), 0);
  endtask

  // Stimulus
  initial begin
    rst     = 1'b1;
    start_s = 1'b0;
    mode_s  = 1'b0;
    #2;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b0);
    wait_idle();
    issue(1'b1);
    wait_idle();

    // start held high with mode churning: each transform keeps its own mode
    start_s = 1'b1;
    repeat (2400) begin
      @(posedge clk); #1;
      mode_s = 1'($urandom);
    end
    start_s = 1'b0;
    wait_idle();

    repeat (3) begin
      repeat ($urandom_range(1, 15)) @(posedge clk);
      issue(1'($urandom_range(0, 1)));
      wait_idle();
    end

    // mid-transform abort, then restart from stage 0
    issue(1'b0);
    repeat (499) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    issue(1'b0);
    wait_idle();

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 Parameter BF_LAT, default 0, meaning butterfly pipeline depth in cycles (0 = combinational butterfly).
REQ-002 Parameter N, default 256, meaning transform length; only 256 is supported.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  request one full transform; sampled only in IDLE.
REQ-006 mode_i  in  1  0 = forward NTT (Cooley-Tukey), 1 = inverse NTT (Gentleman-Sande); latched at start.
REQ-007 busy_o  out  1  high from the cycle after start acceptance until done_o.
REQ-008 done_o  out  1  one-cycle pulse at completion.
REQ-009 rd_en_o  out  1  coefficient-memory read strobe, one butterfly issued per high cycle.
REQ-010 rd_addr_a_o, rd_addr_b_o  out  8 each  read addresses of operands a and b.
REQ-011 twiddle_idx_o  out  8  twiddle ROM index, aligned with operand data (rd + 1 cycle).
REQ-012 sel_butterfly_o  out  1  butterfly type select (= latched mode), aligned with twiddle_idx_o.
REQ-013 sel_red_o  out  1  final-reduction select, aligned with twiddle_idx_o.
REQ-014 wr_en_o  out  1  write strobe, equal to rd_en_o delayed 1+BF_LAT cycles.
REQ-015 wr_addr_a_o, wr_addr_b_o  out  8 each  read addresses delayed 1+BF_LAT cycles.
REQ-016 stage_o  out  3  current stage 0..7.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_i; RUN->DRAIN after 128 issues; DRAIN->RUN (next stage) after 1+BF_LAT cycles if stage<7, else DRAIN->DONE; DONE->IDLE after one cycle.
REQ-018 RUN: rd_en_o high every cycle, butterfly counter bf (7 bits) 0..127.
REQ-019 Stage s: forward len = 128>>s, inverse len = 1<<s; L = log2(len).
REQ-020 Addresses: g = bf>>L, j = (g<<(L+1)) | (bf & (len-1)); rd_addr_a_o = j, rd_addr_b_o = j+len.
REQ-021 Twiddle: forward k = (1<<s) + g; inverse k = 2*(128>>s) - 1 - g; range 1..255, never 0.
REQ-022 sel_red_o high only for butterflies of inverse stage 7; low otherwise.
REQ-023 DRAIN: rd_en_o low; stalls so that no stage reads before the previous stage's last write.
REQ-024 Latency: start accepted at cycle 0, first rd_en_o at cycle 1, done_o at cycle 8*(129+BF_LAT)+1 (1033 for BF_LAT=0).
REQ-025 start_i while busy is ignored; mode_i changes while busy have no effect.
REQ-026 Idle outputs: all strobes low, addresses/indices hold 0.

Reset
REQ-027 rst_i asserted forces IDLE, all outputs 0, all counters and delay lines cleared, immediately and independent of clk_i.
REQ-028 Reset mid-transform aborts it: no done_o and no further wr_en_o pulses; next start_i begins at stage 0.

Structure
REQ-029 Shared package holds N, Q = 8380417, LOG2N = 8, the FSM state enum and the mode encoding.
REQ-030 The write-side alignment (strobe, addresses) is a parameterised delay-line sub-module ntt_delay_line, depth 1+BF_LAT.
REQ-031 ntt_ctrl drives the existing butterfly's twiddle, sel_red and sel_butterfly inputs directly.

Verification
REQ-032 Forward, BF_LAT=0, start at cycle 0 -> cycle 1: a=0, b=128; twiddle_idx=1 at cycle 2; done_o at cycle 1033.
REQ-033 Forward stage 7 -> bf=0: a=0, b=1, k=128; bf=127: a=254, b=255, k=255.
REQ-034 Inverse stage 0 -> bf=0: a=0, b=1, k=255; stage 7 bf=0: a=0, b=128, k=1, sel_red_o=1.
REQ-035 BF_LAT=2 -> wr_* equals rd_* three cycles later; 2-cycle extra drain per stage; done_o at cycle 1049.
REQ-036 start_i held high through a transform -> exactly one done_o, then a new transform starts.
REQ-037 rst_i pulsed at cycle 500 -> outputs 0 asynchronously, no done_o; restart produces stage-0 addresses.
